// File: rtl/router_port_rx.sv
// Store-and-forward receiver for one router output port: deframes SA/DA/LEN/payload/CHK,
// buffers payload speculatively and exposes per-error counters. Optional: ROUTER_RX_CHKSUM_EN.
module router_port_rx #(
  parameter int unsigned PORT_ID    = 1,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  da,
  input  logic        da_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

`ifdef ROUTER_RX_CHKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  localparam int CntOk    = 0;
  localparam int CntChk   = 1;
  localparam int CntMis   = 2;
  localparam int CntLen   = 3;
  localparam int CntTrunc = 4;
  localparam int CntOvf   = 5;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StGetDa   = 3'd1,
    StGetLen  = 3'd2,
    StPayload = 3'd3,
    StGetChk  = 3'd4,
    StDrop    = 3'd5
  } state_e;

  state_e        state_q;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_spec_q, wr_cmt_q, rd_ptr_q, level;
  logic [7:0]    dst_q, rem_q, xor_q;
  logic [31:0]   cnt_q [6];
  logic [31:0]   rdata_q, rd_val;
  logic [8:0]    head;
  logic          trunc, clr, pop;

  // Only the clear address matters on writes; the data is don't-care.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Downstream only ever sees committed entries.
  assign level     = wr_cmt_q - rd_ptr_q;
  assign head      = mem[rd_ptr_q[AW-1:0]];
  assign out_valid = (level != '0);
  assign out_data  = out_valid ? head[7:0] : 8'h00;
  assign out_last  = out_valid & head[8];
  assign pop       = out_valid & out_ready;
  assign rdata     = rdata_q;

  assign clr   = wr && (addr == 8'h20);
  assign trunc = !da_valid && (state_q inside {StGetDa, StGetLen, StPayload, StGetChk});

  always_comb begin
    rd_val = '0;
    case (addr)
      8'h00:   rd_val = cnt_q[CntOk];
      8'h04:   rd_val = cnt_q[CntChk];
      8'h08:   rd_val = cnt_q[CntMis];
      8'h0C:   rd_val = cnt_q[CntLen];
      8'h10:   rd_val = cnt_q[CntTrunc];
      8'h14:   rd_val = cnt_q[CntOvf];
      8'h18: begin
        rd_val[15:8] = 8'(level);
        rd_val[2:0]  = state_q;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_spec_q <= '0;
      wr_cmt_q  <= '0;
      rd_ptr_q  <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      xor_q     <= '0;
      rdata_q   <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);

      if (trunc) begin
        cnt_q[CntTrunc] <= sat_inc(cnt_q[CntTrunc]);
        wr_spec_q       <= wr_cmt_q;
        state_q         <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (da_valid) begin
              xor_q   <= da;
              state_q <= StGetDa;
            end
          end
          StGetDa: begin
            dst_q   <= da;
            xor_q   <= xor_q ^ da;
            state_q <= StGetLen;
          end
          StGetLen: begin
            xor_q <= xor_q ^ da;
            rem_q <= da;
            if (da == 8'd0) begin
              cnt_q[CntLen] <= sat_inc(cnt_q[CntLen]);
              state_q       <= StDrop;
            end else if (32'(dst_q) != PORT_ID) begin
              cnt_q[CntMis] <= sat_inc(cnt_q[CntMis]);
              state_q       <= StDrop;
            end else if (32'(da) > (FIFO_DEPTH - 32'(level))) begin
              cnt_q[CntOvf] <= sat_inc(cnt_q[CntOvf]);
              state_q       <= StDrop;
            end else begin
              state_q <= StPayload;
            end
          end
          StPayload: begin
            mem[wr_spec_q[AW-1:0]] <= {(rem_q == 8'd1), da};
            wr_spec_q <= wr_spec_q + PW'(1);
            xor_q     <= xor_q ^ da;
            rem_q     <= rem_q - 8'd1;
            if (rem_q == 8'd1) state_q <= StGetChk;
          end
          StGetChk: begin
            if (!ChkEn || (da == xor_q)) begin
              wr_cmt_q     <= wr_spec_q;
              cnt_q[CntOk] <= sat_inc(cnt_q[CntOk]);
            end else begin
              cnt_q[CntChk] <= sat_inc(cnt_q[CntChk]);
              wr_spec_q     <= wr_cmt_q;
            end
            state_q <= StIdle;
          end
          StDrop: begin
            if (!da_valid) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end

      if (rd) rdata_q <= rd_val;
      // Clear wins over a same-cycle increment.
      if (clr) begin
        for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_port_rx.sv
// Scoreboard bench for router_port_rx: expected payload bytes are queued as frames are sent
// and popped by a monitor on each output handshake; counters are checked over the register bus.
module tb_router_port_rx;

`ifdef ROUTER_RX_CHKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, da_valid, out_ready, wr, rd;
  logic [7:0]  da, addr, out_data;
  logic [31:0] wdata, rdata;
  logic        out_valid, out_last;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [8:0]  exp_q [$];
  logic [7:0]  pl [$];
  logic [31:0] exp_cnt [6];
  logic [31:0] v;

  router_port_rx #(.PORT_ID(1), .FIFO_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .da(da), .da_valid(da_valid),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        check_eq("out_byte", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
        n_out++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    da = b;
    da_valid = 1'b1;
    tick();
  endtask

  task automatic gap(input int n);
    da_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic mk_payload(input int n, input logic [7:0] seed);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'(seed + 8'(i * 13)));
  endtask

  // Sends SA=3, dst, len, the first npay bytes of pl and, if complete, the checksum.
  task automatic send_frame(input logic [7:0] dst, input logic [7:0] len, input int npay,
                            input bit bad_chk, input bit deliver, input bit clr_at_chk);
    logic [7:0] x;
    x = 8'h03 ^ dst ^ len;
    send(8'h03);
    send(dst);
    send(len);
    for (int i = 0; i < npay; i++) begin
      x = x ^ pl[i];
      if (deliver) exp_q.push_back({(i == npay - 1), pl[i]});
      send(pl[i]);
    end
    if (npay >= 32'(len)) begin
      if (clr_at_chk) begin
        wr = 1'b1;
        addr = 8'h20;
        wdata = 32'h0;
      end
      send(bad_chk ? 8'h00 : x);
      wr = 1'b0;
    end
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [31:0] d);
    rd = 1'b1;
    addr = a;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    wr = 1'b1;
    addr = a;
    wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic check_cnts();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      read_reg(8'(i * 4), d);
      check_eq($sformatf("cnt_%0h", i * 4), d, exp_cnt[i]);
    end
  endtask

  task automatic check_status(input logic [7:0] lvl);
    logic [31:0] d;
    read_reg(8'h18, d);
    check_eq("status", d, {16'd0, lvl, 8'd0});
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
    tick();
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    check_eq("valid_after_drain", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; da_valid = 1'b0; da = 8'h00; out_ready = 1'b0;
    wr = 1'b0; rd = 1'b0; addr = 8'h00; wdata = 32'h0;
    for (int i = 0; i < 6; i++) exp_cnt[i] = 32'd0;
    repeat (3) tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    tick();
    check_cnts();
    check_status(8'd0);

    // Good packet 0xAA 0x55
    out_ready = 1'b1;
    pl.delete(); pl.push_back(8'hAA); pl.push_back(8'h55);
    send_frame(8'd1, 8'd2, 2, 1'b0, 1'b1, 1'b0);
    gap(4);
    exp_cnt[0]++;
    drain();
    check_cnts();

    // Bad checksum
    send_frame(8'd1, 8'd2, 2, 1'b1, !ChkEn, 1'b0);
    gap(4);
    if (ChkEn) exp_cnt[1]++;
    else exp_cnt[0]++;
    drain();
    check_cnts();

    // Misroute, then a good packet
    mk_payload(3, 8'h10);
    send_frame(8'd2, 8'd3, 3, 1'b0, 1'b0, 1'b0);
    gap(1);
    send_frame(8'd1, 8'd3, 3, 1'b0, 1'b1, 1'b0);
    gap(4);
    exp_cnt[2]++; exp_cnt[0]++;
    drain();

    // LEN = 0
    send_frame(8'd1, 8'd0, 0, 1'b0, 1'b0, 1'b0);
    gap(2);
    exp_cnt[3]++;
    check_cnts();

    // Truncation after the 2nd of 5 payload bytes, then two back-to-back packets
    mk_payload(5, 8'h40);
    send_frame(8'd1, 8'd5, 2, 1'b0, 1'b0, 1'b0);
    gap(2);
    exp_cnt[4]++;
    check_status(8'd0);
    mk_payload(4, 8'h70);
    send_frame(8'd1, 8'd4, 4, 1'b0, 1'b1, 1'b0);
    mk_payload(3, 8'h90);
    send_frame(8'd1, 8'd3, 3, 1'b0, 1'b1, 1'b0);
    gap(4);
    exp_cnt[0] += 2;
    drain();
    check_cnts();

    // Overflow with the consumer stalled
    out_ready = 1'b0;
    mk_payload(60, 8'h01);
    send_frame(8'd1, 8'd60, 60, 1'b0, 1'b1, 1'b0);
    gap(2);
    mk_payload(8, 8'hC0);
    send_frame(8'd1, 8'd8, 8, 1'b0, 1'b0, 1'b0);
    gap(2);
    exp_cnt[0]++; exp_cnt[5]++;
    check_status(8'd60);
    check_eq("stall_valid", 32'(out_valid), 32'd1);
    repeat (3) tick();
    check_eq("stall_head", {23'd0, out_last, out_data}, {23'd0, exp_q[0]});
    // Exactly fills the remaining space
    mk_payload(4, 8'hE0);
    send_frame(8'd1, 8'd4, 4, 1'b0, 1'b1, 1'b0);
    gap(2);
    exp_cnt[0]++;
    check_status(8'd64);
    check_eq("stall_head2", {23'd0, out_last, out_data}, {23'd0, exp_q[0]});
    n_out = 0;
    out_ready = 1'b1;
    drain();
    check_eq("released_bytes", 32'(n_out), 32'd64);
    check_status(8'd0);
    check_cnts();

    // Clear in the same cycle as a PKT_OK increment
    mk_payload(2, 8'h33);
    send_frame(8'd1, 8'd2, 2, 1'b0, 1'b1, 1'b1);
    gap(4);
    for (int i = 0; i < 6; i++) exp_cnt[i] = 32'd0;
    drain();
    check_cnts();

    // Writes elsewhere ignored, unmapped reads zero, rdata holds
    send_frame(8'd1, 8'd2, 2, 1'b0, 1'b1, 1'b0);
    gap(4);
    exp_cnt[0]++;
    drain();
    write_reg(8'h00, 32'h0000_1234);
    write_reg(8'h1C, 32'hFFFF_FFFF);
    read_reg(8'h00, v);
    check_eq("pkt_ok_after_wr", v, exp_cnt[0]);
    repeat (3) tick();
    check_eq("rdata_hold", rdata, exp_cnt[0]);
    read_reg(8'h1C, v);
    check_eq("unmapped_1c", v, 32'd0);
    read_reg(8'h20, v);
    check_eq("unmapped_20", v, 32'd0);

    // Reset mid-packet: lost, not counted
    mk_payload(4, 8'h55);
    send_frame(8'd1, 8'd4, 2, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    da_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) exp_cnt[i] = 32'd0;
    check_cnts();
    check_status(8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
